// File: rtl/usart_baud_engine.sv
// USART baud engine: fractional prescaler driving async oversampling, sync-master
// XCK generation and sync-slave edge strobes for the transmitter and receiver.
module usart_baud_engine #(
  parameter int DIV_W  = 12,
  parameter int FRAC_W = 4,
  parameter int OSR_W  = 5
) (
  input  logic              i_fosk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_ubrr_we,
  input  logic [DIV_W-1:0]  i_ubrr,
  input  logic [FRAC_W-1:0] i_frac,
  input  logic [OSR_W-1:0]  i_osr_m1,
  input  logic              i_umsel,
  input  logic              i_xck_dir,
  input  logic              i_ucpol,
  input  logic              i_xck,
  input  logic              i_rx_resync,
  output logic              o_txclk,
  output logic              o_rxclk,
  output logic              o_rxmid,
  output logic              o_xck
);

  logic [DIV_W-1:0]  r_ubrr;
  logic [FRAC_W-1:0] r_frac;
  logic [OSR_W-1:0]  r_osr_m1;
  logic [DIV_W:0]    r_presc;
  logic [FRAC_W-1:0] r_acc;
  logic [OSR_W-1:0]  r_os;
  logic              r_tog;
  logic              r_sync1, r_sync2, r_xck_d;
  logic              r_txclk, r_rxclk, r_rxmid, r_xck;

  logic              w_tick, w_async, w_master, w_slave, w_resync;
  logic [FRAC_W:0]   w_acc_sum;
  logic [DIV_W:0]    w_reload;
  logic [OSR_W-1:0]  w_osr_eff, w_os_next;
  logic              w_os_wrap, w_tog_next, w_xck_rise, w_xck_fall;

  assign w_async  = ~i_umsel;
  assign w_master = i_umsel & i_xck_dir;
  assign w_slave  = i_umsel & ~i_xck_dir;
  assign w_tick   = i_en & (r_presc == '0);
  assign w_resync = i_en & w_async & i_rx_resync;

  // Carry out of the fraction accumulator lengthens the following period by one cycle.
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac};
  assign w_reload  = {1'b0, r_ubrr} + {{DIV_W{1'b0}}, w_acc_sum[FRAC_W]};

  assign w_osr_eff = (r_osr_m1 < OSR_W'(3)) ? OSR_W'(3) : r_osr_m1;
  assign w_os_wrap = (r_os >= w_osr_eff);
  assign w_os_next = w_os_wrap ? '0 : r_os + OSR_W'(1);

  assign w_tog_next = i_ubrr_we ? 1'b0 : ((w_tick & w_master) ? ~r_tog : r_tog);
  assign w_xck_rise = r_sync2 & ~r_xck_d;
  assign w_xck_fall = ~r_sync2 & r_xck_d;

  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ubrr   <= '0;
      r_frac   <= '0;
      r_osr_m1 <= OSR_W'(15);
      r_presc  <= '0;
      r_acc    <= '0;
      r_os     <= '0;
      r_tog    <= 1'b0;
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_xck_d  <= 1'b0;
      r_txclk  <= 1'b0;
      r_rxclk  <= 1'b0;
      r_rxmid  <= 1'b0;
      r_xck    <= 1'b0;
    end else begin
      r_sync1 <= i_xck;
      r_sync2 <= r_sync1;
      r_xck_d <= r_sync2;
      r_tog   <= w_tog_next;
      r_xck   <= (i_en & w_master) ? (w_tog_next ^ i_ucpol) : i_ucpol;
      r_txclk <= 1'b0;
      r_rxclk <= 1'b0;
      r_rxmid <= 1'b0;
      if (i_ubrr_we) begin
        r_ubrr   <= i_ubrr;
        r_frac   <= i_frac;
        r_osr_m1 <= i_osr_m1;
        r_presc  <= {1'b0, i_ubrr};
        r_acc    <= '0;
        r_os     <= '0;
      end else if (!i_en) begin
        r_presc <= {1'b0, r_ubrr};
      end else if (w_resync) begin
        // Realign the receiver to the start bit; any coincident tick is dropped.
        r_os    <= '0;
        r_presc <= {1'b0, r_ubrr};
      end else begin
        r_presc <= w_tick ? w_reload : r_presc - 1'b1;
        if (w_tick) begin
          r_acc <= w_acc_sum[FRAC_W-1:0];
          if (w_async) begin
            r_os    <= w_os_next;
            r_rxclk <= 1'b1;
            r_txclk <= w_os_wrap;
            r_rxmid <= (w_os_next == (w_osr_eff >> 1));
          end else if (w_master) begin
            r_txclk <= ~r_tog;
            r_rxclk <= r_tog;
          end
        end
        if (w_slave) begin
          r_txclk <= i_ucpol ? w_xck_fall : w_xck_rise;
          r_rxclk <= i_ucpol ? w_xck_rise : w_xck_fall;
        end
      end
    end
  end

  assign o_txclk = r_txclk;
  assign o_rxclk = r_rxclk;
  assign o_rxmid = r_rxmid;
  assign o_xck   = r_xck;

endmodule

// File: tb/tb_usart_baud_engine.sv
// Directed bench for usart_baud_engine: expected strobe cycles are queued per
// stimulus step and matched against strobes as they appear.
module tb_usart_baud_engine;

  logic        clk = 1'b0;
  logic        i_rst_n, i_en, i_ubrr_we, i_umsel, i_xck_dir, i_ucpol, i_xck, i_rx_resync;
  logic [11:0] i_ubrr;
  logic [3:0]  i_frac;
  logic [4:0]  i_osr_m1;
  logic        o_txclk, o_rxclk, o_rxmid, o_xck;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int q_tx[$], q_rx[$], q_mid[$];
  int xck_chk = 0;
  int rx_cnt = 0, rx_t1 = 0, rx_t17 = 0;

  usart_baud_engine #(.DIV_W(12), .FRAC_W(4), .OSR_W(5)) dut (
    .i_fosk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_ubrr_we(i_ubrr_we),
    .i_ubrr(i_ubrr), .i_frac(i_frac), .i_osr_m1(i_osr_m1), .i_umsel(i_umsel),
    .i_xck_dir(i_xck_dir), .i_ucpol(i_ucpol), .i_xck(i_xck), .i_rx_resync(i_rx_resync),
    .o_txclk(o_txclk), .o_rxclk(o_rxclk), .o_rxmid(o_rxmid), .o_xck(o_xck)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample on the falling edge and retire any strobe against the queues.
  task automatic step();
    @(negedge clk);
    if (q_tx.size() > 0 && q_tx[0] < cyc) chk_int("txclk_missing", -1, q_tx.pop_front());
    if (q_rx.size() > 0 && q_rx[0] < cyc) chk_int("rxclk_missing", -1, q_rx.pop_front());
    if (q_mid.size() > 0 && q_mid[0] < cyc) chk_int("rxmid_missing", -1, q_mid.pop_front());
    if (o_txclk) begin
      if (q_tx.size() == 0) chk_int("txclk_extra", cyc, -1);
      else chk_int("txclk_time", cyc, q_tx.pop_front());
      if (xck_chk != 0) chk("xck_at_tx", o_xck, ~i_ucpol);
    end
    if (o_rxclk) begin
      rx_cnt++;
      if (rx_cnt == 1) rx_t1 = cyc;
      if (rx_cnt == 17) rx_t17 = cyc;
      if (q_rx.size() == 0) chk_int("rxclk_extra", cyc, -1);
      else chk_int("rxclk_time", cyc, q_rx.pop_front());
      if (xck_chk != 0) chk("xck_at_rx", o_xck, i_ucpol);
    end
    if (o_rxmid) begin
      if (q_mid.size() == 0) chk_int("rxmid_extra", cyc, -1);
      else chk_int("rxmid_time", cyc, q_mid.pop_front());
    end
  endtask

  task automatic run_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic drain(input string tag);
    chk_int({tag, "_tx_left"}, q_tx.size(), 0);
    chk_int({tag, "_rx_left"}, q_rx.size(), 0);
    chk_int({tag, "_mid_left"}, q_mid.size(), 0);
  endtask

  task automatic load(input int ubrr, input int frac, input int osr, output int w);
    w = cyc;
    i_ubrr = 12'(ubrr);
    i_frac = 4'(frac);
    i_osr_m1 = 5'(osr);
    i_ubrr_we = 1'b1;
    rx_cnt = 0;
    step();
    i_ubrr_we = 1'b0;
  endtask

  initial begin
    int w, r, e, t, acc, flips;
    i_rst_n = 1'b0; i_en = 1'b1; i_ubrr_we = 1'b0; i_umsel = 1'b0; i_xck_dir = 1'b0;
    i_ucpol = 1'b0; i_xck = 1'b0; i_rx_resync = 1'b0; i_ubrr = '0; i_frac = '0; i_osr_m1 = 5'd15;
    step();
    step();
    chk("rst_txclk", o_txclk, 1'b0);
    chk("rst_rxclk", o_rxclk, 1'b0);
    chk("rst_rxmid", o_rxmid, 1'b0);
    chk("rst_xck", o_xck, 1'b0);
    i_rst_n = 1'b1;

    // Async, ubrr=0, osr_m1=1 clamped to 3: ratio 4, mid at count 1.
    load(0, 0, 1, w);
    for (int k = 1; k <= 12; k++) begin
      q_rx.push_back(w + 1 + k);
      if (k % 4 == 0) q_tx.push_back(w + 1 + k);
      if (k % 4 == 1) q_mid.push_back(w + 1 + k);
    end
    run_until(w + 13);
    drain("osr_clamp");

    // Async, ubrr=3, ratio 16.
    load(3, 0, 15, w);
    for (int k = 1; k <= 40; k++) begin
      q_rx.push_back(w + 1 + 4 * k);
      if (k % 16 == 0) q_tx.push_back(w + 1 + 4 * k);
      if (k % 16 == 7) q_mid.push_back(w + 1 + 4 * k);
    end
    run_until(w + 161);
    drain("async16");

    // Disable: strobes stop, o_xck follows polarity; re-enable resumes held count (8).
    i_en = 1'b0;
    i_ucpol = 1'b1;
    repeat (8) step();
    chk("dis_xck_pol", o_xck, 1'b1);
    i_ucpol = 1'b0;
    repeat (4) step();
    chk("dis_xck_pol0", o_xck, 1'b0);
    i_en = 1'b1;
    e = cyc;
    for (int k = 1; k <= 8; k++) q_rx.push_back(e + 4 * k);
    q_tx.push_back(e + 32);
    run_until(e + 32);
    drain("reenable");

    // Fractional: ubrr=3, frac=8 gives alternating 4/5 periods.
    load(3, 8, 15, w);
    t = w + 5;
    acc = 0;
    for (int k = 1; k <= 17; k++) begin
      q_rx.push_back(t);
      if (k % 16 == 0) q_tx.push_back(t);
      if (k % 16 == 7) q_mid.push_back(t);
      acc = acc + 8;
      t = t + 4 + (acc >= 16 ? 1 : 0);
      acc = acc % 16;
    end
    run_until(q_rx[q_rx.size() - 1]);
    drain("frac");
    chk_int("frac_span16", rx_t17 - rx_t1, 72);

    // Resync mid-count with ubrr=1.
    load(1, 0, 15, w);
    for (int k = 1; k <= 5; k++) q_rx.push_back(w + 1 + 2 * k);
    r = w + 11;
    run_until(r);
    i_rx_resync = 1'b1;
    step();
    i_rx_resync = 1'b0;
    for (int j = 1; j <= 17; j++) q_rx.push_back(r + 1 + 2 * j);
    q_mid.push_back(r + 15);
    q_tx.push_back(r + 33);
    run_until(r + 35);
    drain("resync");

    // Sync master, ubrr=2, both polarities.
    i_umsel = 1'b1;
    i_xck_dir = 1'b1;
    xck_chk = 1;
    for (int p = 0; p < 2; p++) begin
      i_ucpol = p[0];
      load(2, 0, 15, w);
      for (int k = 1; k <= 8; k++) begin
        if (k % 2 == 1) q_tx.push_back(w + 1 + 3 * k);
        else q_rx.push_back(w + 1 + 3 * k);
      end
      run_until(w + 25);
      drain(p == 0 ? "master_pol0" : "master_pol1");
    end
    xck_chk = 0;

    // Sync slave, UCPOL=1, pin period 20 cycles.
    i_xck_dir = 1'b0;
    i_ucpol = 1'b1;
    i_xck = 1'b0;
    load(0, 0, 15, w);
    flips = 0;
    while (cyc < w + 90) begin
      step();
      if (flips < 8 && ((cyc - w) % 10) == 0) begin
        i_xck = ~i_xck;
        if (i_xck) q_rx.push_back(cyc + 3);
        else q_tx.push_back(cyc + 3);
        flips++;
      end
    end
    drain("slave");
    chk("slave_xck_pol", o_xck, 1'b1);

    // Write coincident with a tick, then reset mid-period.
    i_umsel = 1'b0;
    i_ucpol = 1'b0;
    load(3, 0, 15, w);
    q_rx.push_back(w + 5);
    q_rx.push_back(w + 9);
    run_until(w + 12);
    load(5, 0, 15, w);
    q_rx.push_back(w + 7);
    run_until(w + 10);
    drain("we_tick");
    i_rst_n = 1'b0;
    step();
    chk("rstmid_txclk", o_txclk, 1'b0);
    chk("rstmid_rxclk", o_rxclk, 1'b0);
    chk("rstmid_rxmid", o_rxmid, 1'b0);
    step();
    chk("rstmid_xck", o_xck, 1'b0);
    i_rst_n = 1'b1;
    r = cyc;
    for (int k = 1; k <= 16; k++) q_rx.push_back(r + k);
    q_mid.push_back(r + 7);
    q_tx.push_back(r + 16);
    run_until(r + 16);
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
